tube_scan_controller: RTL and testbench

//  Parametrised multiplexed 7-segment scan driver for the taximeter display (distance/price fields).

---
 rtl/tube_pkg.sv | 56 +++++
 rtl/tube_scan_if.sv | 27 ++
 rtl/tube_seg_encoder.sv | 18 +
 rtl/tube_scan_controller.sv | 183 ++++++++++++++++++
 tb/tb_tube_scan_controller.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/tube_pkg.sv
// Shared segment patterns, symbol codes and scan-state type for the taximeter tube driver.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active-high before any pin inversion.
package tube_pkg;

    localparam logic [7:0] SEG_0    = 8'h3F;
    localparam logic [7:0] SEG_1    = 8'h06;
    localparam logic [7:0] SEG_2    = 8'h5B;
    localparam logic [7:0] SEG_3    = 8'h4F;
    localparam logic [7:0] SEG_4    = 8'h66;
    localparam logic [7:0] SEG_5    = 8'h6D;
    localparam logic [7:0] SEG_6    = 8'h7D;
    localparam logic [7:0] SEG_7    = 8'h07;
    localparam logic [7:0] SEG_8    = 8'h7F;
    localparam logic [7:0] SEG_9    = 8'h6F;
    localparam logic [7:0] SEG_P    = 8'h73;
    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_E    = 8'h79;
    localparam logic [7:0] SEG_R    = 8'h50;
    localparam logic [7:0] SEG_OFF  = 8'h00;

    localparam logic [3:0] CODE_P      = 4'd10;
    localparam logic [3:0] CODE_DASH   = 4'd11;
    localparam logic [3:0] CODE_BLANK  = 4'd12;
    localparam logic [3:0] CODE_E      = 4'd13;
    localparam logic [3:0] CODE_R      = 4'd14;
    localparam logic [3:0] CODE_BLANK2 = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_SHOW
    } scan_state_t;

    function automatic logic [7:0] seg_encode(input logic [3:0] code);
        logic [7:0] seg;
        case (code)
            4'd0:        seg = SEG_0;
            4'd1:        seg = SEG_1;
            4'd2:        seg = SEG_2;
            4'd3:        seg = SEG_3;
            4'd4:        seg = SEG_4;
            4'd5:        seg = SEG_5;
            4'd6:        seg = SEG_6;
            4'd7:        seg = SEG_7;
            4'd8:        seg = SEG_8;
            4'd9:        seg = SEG_9;
            CODE_P:      seg = SEG_P;
            CODE_DASH:   seg = SEG_DASH;
            CODE_E:      seg = SEG_E;
            CODE_R:      seg = SEG_R;
            default:     seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/tube_scan_if.sv
// Bus between the BCD counter side and the tube scan controller.
// master = counter/board side, slave = scan controller.
interface tube_scan_if #(
    parameter int N_DIGITS = 8
) ();
    localparam int IDX_W = $clog2(N_DIGITS);

    logic                    en;
    logic [4*N_DIGITS-1:0]   digits_code;
    logic [N_DIGITS-1:0]     dp_mask;
    logic [N_DIGITS-1:0]     lzb_group;
    logic [N_DIGITS-1:0]     blink_mask;
    logic [7:0]              seg;
    logic [N_DIGITS-1:0]     dig_sel;
    logic [IDX_W-1:0]        dig_idx;
    logic                    frame_start;

    modport master (
        output en, digits_code, dp_mask, lzb_group, blink_mask,
        input  seg, dig_sel, dig_idx, frame_start
    );

    modport slave (
        input  en, digits_code, dp_mask, lzb_group, blink_mask,
        output seg, dig_sel, dig_idx, frame_start
    );
endinterface

// File: rtl/tube_seg_encoder.sv
// Combinational digit encoder: 4-bit code plus decimal point, with a forced-dark override.
module tube_seg_encoder
    import tube_pkg::*;
(
    input  logic [3:0] code,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (!blank) begin
            seg = seg_encode(code) | {dp, 7'b0000000};
        end
    end

endmodule

// File: rtl/tube_scan_controller.sv
// Multiplexed 7-segment scan driver: slot prescaler, ghost blanking, frame snapshot,
// per-field leading-zero blanking, decimal points and per-digit blink.
module tube_scan_controller
    import tube_pkg::*;
#(
    parameter int N_DIGITS     = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int SEG_ACT_LOW  = 0
) (
    input  logic       clk,
    input  logic       rst,
    tube_scan_if.slave bus
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]    BLANK_LIM = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [FC_W-1:0]     FC_LAST   = FC_W'(BLINK_FRAMES - 1);
    localparam logic [7:0]          SEG_INV   = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [N_DIGITS-1:0] DIG_INV   = (SEG_ACT_LOW != 0) ? '1 : '0;

    scan_state_t         state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [FC_W-1:0]     frame_cnt_reg, frame_cnt_next;
    logic                phase_reg, phase_next;
    logic                enter_frame;
    logic                restart;

    logic [4*N_DIGITS-1:0] snap_code_reg;
    logic [N_DIGITS-1:0]   snap_dp_reg;
    logic [N_DIGITS-1:0]   snap_lzb_reg;
    logic [N_DIGITS-1:0]   snap_blink_reg;
    logic [3:0]            snap_digit [N_DIGITS];

    logic [N_DIGITS-1:0] field_end;
    logic [N_DIGITS-1:0] lzb_blank;
    logic                field_on;
    logic                zero_run;

    logic                show;
    logic                blink_off;
    logic [7:0]          enc_seg;
    logic [N_DIGITS-1:0] dig_sel_next;
    logic [IDX_W-1:0]    dig_idx_next;

    logic [7:0]          seg_reg;
    logic [N_DIGITS-1:0] dig_sel_reg;
    logic [IDX_W-1:0]    dig_idx_reg;
    logic                frame_start_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_unpack
            assign snap_digit[gi] = snap_code_reg[4*gi +: 4];
        end
    endgenerate

    // Scan sequencer: slot counter, digit index and BLANK/SHOW phase within the slot.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        enter_frame = 1'b0;
        restart     = 1'b0;
        if (!bus.en) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            idx_next   = '0;
        end else begin
            if (state_reg == ST_IDLE) begin
                cnt_next    = '0;
                idx_next    = '0;
                enter_frame = 1'b1;
                restart     = 1'b1;
            end else if (cnt_reg == CNT_LAST) begin
                cnt_next = '0;
                if (idx_reg == IDX_LAST) begin
                    idx_next    = '0;
                    enter_frame = 1'b1;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
            state_next = ((BLANK_CYC != 0) && (cnt_next < BLANK_LIM)) ? ST_BLANK : ST_SHOW;
        end
    end

    // Blink phase flips after every BLINK_FRAMES frames; a restart always begins visible.
    always_comb begin
        frame_cnt_next = frame_cnt_reg;
        phase_next     = phase_reg;
        if (!bus.en || restart) begin
            frame_cnt_next = '0;
            phase_next     = 1'b0;
        end else if (enter_frame) begin
            if (frame_cnt_reg == FC_LAST) begin
                frame_cnt_next = '0;
                phase_next     = ~phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + 1'b1;
            end
        end
    end

    // A zero stays dark only while every earlier digit of its field is also zero.
    assign field_end = {1'b1, snap_lzb_reg[N_DIGITS-1:1]};

    always_comb begin
        field_on  = 1'b0;
        zero_run  = 1'b0;
        lzb_blank = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (snap_lzb_reg[i]) begin
                field_on = 1'b1;
                zero_run = 1'b1;
            end
            zero_run     = field_on && zero_run && (snap_digit[i] == 4'd0);
            lzb_blank[i] = zero_run && !field_end[i] && !snap_dp_reg[i];
        end
    end

    assign show      = bus.en && (state_reg == ST_SHOW);
    assign blink_off = phase_reg && snap_blink_reg[idx_reg];

    tube_seg_encoder u_encoder (
        .code  (snap_digit[idx_reg]),
        .dp    (snap_dp_reg[idx_reg]),
        .blank (!show || blink_off || lzb_blank[idx_reg]),
        .seg   (enc_seg)
    );

    assign dig_sel_next = show ? (N_DIGITS'(1) << idx_reg) : '0;
    assign dig_idx_next = (bus.en && (state_reg != ST_IDLE)) ? idx_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            idx_reg         <= '0;
            frame_cnt_reg   <= '0;
            phase_reg       <= 1'b0;
            snap_code_reg   <= '0;
            snap_dp_reg     <= '0;
            snap_lzb_reg    <= '0;
            snap_blink_reg  <= '0;
            seg_reg         <= SEG_INV;
            dig_sel_reg     <= DIG_INV;
            dig_idx_reg     <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            frame_cnt_reg <= frame_cnt_next;
            phase_reg     <= phase_next;
            if (enter_frame) begin
                snap_code_reg  <= bus.digits_code;
                snap_dp_reg    <= bus.dp_mask;
                snap_lzb_reg   <= bus.lzb_group;
                snap_blink_reg <= bus.blink_mask;
            end
            seg_reg         <= enc_seg ^ SEG_INV;
            dig_sel_reg     <= dig_sel_next ^ DIG_INV;
            dig_idx_reg     <= dig_idx_next;
            frame_start_reg <= enter_frame;
        end
    end

    assign bus.seg         = seg_reg;
    assign bus.dig_sel     = dig_sel_reg;
    assign bus.dig_idx     = dig_idx_reg;
    assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_tube_scan_controller.sv
// Directed bench for tube_scan_controller with a 4-digit, 8-cycle-slot configuration;
// a second, active-low instance shares the stimulus to check pin inversion.
module tb_tube_scan_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tube_scan_if #(.N_DIGITS(4)) bus ();
    tube_scan_if #(.N_DIGITS(4)) bus_inv ();

    assign bus_inv.en          = bus.en;
    assign bus_inv.digits_code = bus.digits_code;
    assign bus_inv.dp_mask     = bus.dp_mask;
    assign bus_inv.lzb_group   = bus.lzb_group;
    assign bus_inv.blink_mask  = bus.blink_mask;

    tube_scan_controller #(
        .N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2), .SEG_ACT_LOW(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    tube_scan_controller #(
        .N_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2), .SEG_ACT_LOW(1)
    ) dut_inv (
        .clk (clk),
        .rst (rst),
        .bus (bus_inv)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] seg_log      [32];
    logic [7:0] seg_inv_log  [32];
    logic [3:0] dsel_log     [32];
    logic [3:0] dsel_inv_log [32];
    logic [1:0] idx_log      [32];
    logic       fs_log       [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts on a frame_start cycle and records cycles 0..31 of that frame.
    task automatic capture(input bit do_change, input logic [15:0] new_code);
        for (int c = 0; c < 32; c++) begin
            seg_log[c]      = bus.seg;
            seg_inv_log[c]  = bus_inv.seg;
            dsel_log[c]     = bus.dig_sel;
            dsel_inv_log[c] = bus_inv.dig_sel;
            idx_log[c]      = bus.dig_idx;
            fs_log[c]       = bus.frame_start;
            if (do_change && c == 10) bus.digits_code = new_code;
            if (c < 31) tick();
        end
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.frame_start && n < 80);
        if (!bus.frame_start) check("frame_start_timeout", 32'd0, 32'd1);
    endtask

    // Pins lag the counter by one cycle: slot k is dark at 8k+1..8k+2 and lit at 8k+3..8k+8.
    task automatic check_frame(input string tag, input logic [31:0] exp_segs);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_seg%0d", tag, k), 32'(seg_log[8*k+5]), 32'(exp_segs[8*k +: 8]));
            check($sformatf("%s_dsel%0d", tag, k), 32'(dsel_log[8*k+5]), 32'(1) << k);
            check($sformatf("%s_idx%0d", tag, k), 32'(idx_log[8*k+5]), 32'(k));
            check($sformatf("%s_ghost%0d", tag, k), {16'(dsel_log[8*k+1]), 16'(seg_log[8*k+2])}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int fs_extra;
        rst                = 1'b1;
        bus.en             = 1'b0;
        bus.digits_code    = 16'h4321;
        bus.dp_mask        = 4'b0000;
        bus.lzb_group      = 4'b0000;
        bus.blink_mask     = 4'b0000;
        repeat (3) tick();
        check("rst_seg", 32'(bus.seg), 32'h00);
        check("rst_dsel", 32'(bus.dig_sel), 32'h0);
        check("rst_idx", 32'(bus.dig_idx), 32'h0);
        check("rst_fs", 32'(bus.frame_start), 32'h0);
        check("rst_inv_seg", 32'(bus_inv.seg), 32'hFF);
        check("rst_inv_dsel", 32'(bus_inv.dig_sel), 32'hF);

        // Basic scan of digits 1,2,3,4
        rst    = 1'b0;
        bus.en = 1'b1;
        tick();
        check("t1_start_fs", 32'(bus.frame_start), 32'd1);
        capture(1'b0, 16'h0);
        check_frame("t1", 32'h664F5B06);
        fs_extra = 0;
        for (int c = 1; c < 32; c++) fs_extra += int'(fs_log[c]);
        check("t1_fs_pulses_mid_frame", 32'(fs_extra), 32'd0);
        check("t1_inv_seg0", 32'(seg_inv_log[5]), 32'hF9);
        check("t1_inv_dsel0", 32'(dsel_inv_log[5]), 32'hE);
        check("t1_inv_ghost", {16'(dsel_inv_log[1]), 16'(seg_inv_log[1])}, {16'hF, 16'hFF});

        // Leading-zero blanking in one field, then a decimal point, then symbols
        bus.digits_code = 16'h0500;
        bus.lzb_group   = 4'b0001;
        wait_frame(n);
        check("t1_period", 32'(n), 32'd1);
        capture(1'b0, 16'h0);
        check_frame("t2_lzb", 32'h3F6D0000);

        bus.dp_mask = 4'b0010;
        wait_frame(n);
        capture(1'b0, 16'h0);
        check_frame("t2_dp", 32'h3F6DBF00);

        bus.dp_mask     = 4'b0000;
        bus.lzb_group   = 4'b0000;
        bus.digits_code = 16'hEDBA;
        wait_frame(n);
        capture(1'b0, 16'h0);
        check_frame("t2_sym", 32'h50794073);

        bus.digits_code = 16'h90FC;
        wait_frame(n);
        capture(1'b0, 16'h0);
        check_frame("t2_blank_codes", 32'h6F3F0000);

        // Two fields of all zeros: each field keeps its last digit
        bus.digits_code = 16'h0000;
        bus.lzb_group   = 4'b0101;
        wait_frame(n);
        capture(1'b0, 16'h0);
        check_frame("t3_fields", 32'h3F003F00);

        // Mid-frame input change is held off until the next frame
        bus.digits_code = 16'h4321;
        bus.lzb_group   = 4'b0000;
        wait_frame(n);
        capture(1'b1, 16'h8765);
        check_frame("t4_hold", 32'h664F5B06);
        wait_frame(n);
        capture(1'b0, 16'h0);
        check_frame("t4_new", 32'h7F077D6D);

        // Blink digit 1 from a clean restart
        bus.en = 1'b0;
        tick();
        bus.digits_code = 16'h4311;
        bus.blink_mask  = 4'b0010;
        bus.en          = 1'b1;
        tick();
        check("t5_start_fs", 32'(bus.frame_start), 32'd1);
        for (int f = 0; f < 6; f++) begin
            if (f != 0) wait_frame(n);
            capture(1'b0, 16'h0);
            check($sformatf("t5_f%0d_seg1", f), 32'(seg_log[13]),
                  (f == 2 || f == 3) ? 32'h00 : 32'h06);
            check($sformatf("t5_f%0d_dsel1", f), 32'(dsel_log[13]), 32'h2);
            check($sformatf("t5_f%0d_seg0", f), 32'(seg_log[5]), 32'h06);
        end

        // Drop en mid-slot 2, then restart
        wait_frame(n);
        repeat (20) tick();
        check("t6_slot2_dsel", 32'(bus.dig_sel), 32'h4);
        bus.en = 1'b0;
        tick();
        check("t6_off_seg", 32'(bus.seg), 32'h00);
        check("t6_off_dsel", 32'(bus.dig_sel), 32'h0);
        check("t6_off_inv", {16'(bus_inv.dig_sel), 16'(bus_inv.seg)}, {16'hF, 16'hFF});
        repeat (3) tick();
        check("t6_dark_fs", 32'(bus.frame_start), 32'd0);
        bus.en = 1'b1;
        tick();
        check("t6_restart_fs", 32'(bus.frame_start), 32'd1);
        capture(1'b0, 16'h0);
        check_frame("t6_resume", 32'h664F0606);

        // Same with a reset pulse mid-frame
        wait_frame(n);
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("t7_rst_seg", 32'(bus.seg), 32'h00);
        check("t7_rst_dsel", 32'(bus.dig_sel), 32'h0);
        check("t7_rst_inv", {16'(bus_inv.dig_sel), 16'(bus_inv.seg)}, {16'hF, 16'hFF});
        rst = 1'b0;
        tick();
        check("t7_restart_fs", 32'(bus.frame_start), 32'd1);
        capture(1'b0, 16'h0);
        check_frame("t7_resume", 32'h664F0606);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
